branch_unit_ras: RTL and testbench
==================================

Name: branch_unit_ras

Overview:
Next-generation branch resolution unit for the processor's fetch/decode path.
- Resolves BNE, BEQ and J, and adds CALL/RET support through an internal circular return-address stack (RAS).
- Outputs are registered. Issues a one-cycle restart request to the fetch stage and squashes the single shadow instruction that follows a taken restart.
- Sits between the ALU zero flag/decode fields and the instruction-address register.

Parameters:
- IA_WIDTH, 12, instruction address width.
- RAS_DEPTH, 8, return-address stack entries (power of two, ≥2).
- CNT_WIDTH, 16, statistics counter width (used only with BRANCH_STATS_EN).

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- valid_i  in  1  operation_i and the other inputs describe a real instruction this cycle.
- operation_i  in  7  opcode (same 7-bit encoding as decode).
- alu_zero_i  in  1  ALU zero flag for the current instruction.
- label1_i  in  IA_WIDTH  branch/jump/call target base.
- label2_i  in  IA_WIDTH  jump offset (J only).
- instr_addr_i  in  IA_WIDTH  address of the current instruction.
- restart_o  out  1  registered one-cycle fetch-redirect pulse.
- restart_addr_o  out  IA_WIDTH  registered redirect target; valid when restart_o=1.
- ras_count_o  out  $clog2(RAS_DEPTH)+1  current stack occupancy.
- ras_overflow_o  out  1  sticky: a CALL was issued with the stack full.
- ras_underflow_o  out  1  sticky: a RET was issued with the stack empty.

Behaviour:
- Reset (rst=1 at edge): restart_o=0, restart_addr_o=0, ras_count_o=0, both sticky flags=0, squash=0, stack pointer=0. Stack contents are don't-care. Reset mid-sequence abandons any pending squash.
- Accepted instruction: valid_i=1 and squash=0. Anything else is a no-op: no state change, restart_o=0 next cycle.
- Latency: decision registered, so restart_o/restart_addr_o appear on the edge after acceptance.
- normal_next = instr_addr_i+1, modulo 2^IA_WIDTH.
- BNE (1001xxx): taken iff alu_zero_i=0; target label1_i.
- BEQ (1010xxx): taken iff alu_zero_i=1; target label1_i.
- J (1100xxx): always taken; target = label1_i+label2_i, truncated to IA_WIDTH.
- CALL (1111011): always taken; target label1_i. Push normal_next.
  - Not full: count+1.
  - Full: overwrite the oldest entry (circular), count stays RAS_DEPTH, set ras_overflow_o.
- RET (1111100):
  - Count>0: pop; target = popped address; count−1.
  - Empty: no restart, set ras_underflow_o, count stays 0.
- All other opcodes: restart_o=0 next cycle; restart_addr_o holds its last value.
- Squash: the register is set on the cycle restart_o is driven high. The next valid_i instruction is the shadow slot and is ignored entirely, including any CALL/RET stack action. Squash clears after one cycle regardless of valid_i.
- Back-to-back: a RET immediately after a CALL (next accepted instruction) pops the just-pushed address.
- Sticky flags clear only on rst.

Optional Feature:
- Macro: BRANCH_STATS_EN.
- Defined: adds outputs taken_count_o and call_depth_max_o, both CNT_WIDTH.
  - taken_count_o increments on every accepted taken branch/J/CALL/RET and saturates at all-ones.
  - call_depth_max_o holds the high-water mark of ras_count_o.
  - Both reset to 0.
- Undefined: ports and logic are absent; the rest of the behaviour is identical.

Decomposition:
- Package branch_pkg holds:
  - the 7-bit opcode constants (BNE, BEQ, J, CALL, RET as casez patterns);
  - typedef ia_t (logic [IA_WIDTH-1:0] default);
  - enum br_kind_e {BR_NONE, BR_COND, BR_JUMP, BR_CALL, BR_RET}, shared with decode.
- One sub-module, ras_stack:
  - parametrised circular LIFO with push/pop/full/empty/count and overwrite-on-full;
  - the top level instantiates it once.

Test Plan:
- Reset, then BEQ with alu_zero_i=1, label1_i=0x040, instr_addr_i=0x010 → next cycle restart_o=1, restart_addr_o=0x040; a following valid BNE is squashed (restart_o=0).
- BNE with alu_zero_i=1, instr_addr_i=0x020 → restart_o=0. J with label1_i=0xFF0, label2_i=0x020 → restart_addr_o=0x010 (wrap).
- CALL at 0x100 to 0x200, then RET (after the squash slot) → restart_addr_o=0x101, ras_count_o goes 1→0.
- Nine CALLs at addresses 0x001…0x009 with RAS_DEPTH=8 → ras_overflow_o=1, count=8. Eight RETs return 0x00A down to 0x003 (0x002 was overwritten).
- RET on empty stack → restart_o=0, ras_underflow_o=1; assert rst for one cycle → flag clears, count=0.
- Assert rst in the cycle a CALL produces restart_o=1 → after reset, squash=0, ras_count_o=0, and the next valid BEQ taken is accepted normally.

Source files
------------

// File: rtl/branch_pkg.sv
// Shared branch-unit definitions: opcode patterns, address type and the
// branch-kind classification also used by decode.
package branch_pkg;

  localparam int IA_WIDTH = 12;

  typedef logic [IA_WIDTH-1:0] ia_t;

  // Opcode patterns, matched with casez (? bits are don't-care)
  localparam logic [6:0] OP_BNE  = 7'b1001???;
  localparam logic [6:0] OP_BEQ  = 7'b1010???;
  localparam logic [6:0] OP_J    = 7'b1100???;
  localparam logic [6:0] OP_CALL = 7'b1111011;
  localparam logic [6:0] OP_RET  = 7'b1111100;

  typedef enum logic [2:0] {
    BR_NONE,
    BR_COND,
    BR_JUMP,
    BR_CALL,
    BR_RET
  } br_kind_e;

  // Classify an opcode into the branch kind it represents
  function automatic br_kind_e decode_kind(input logic [6:0] op);
    br_kind_e kind;
    kind = BR_NONE;
    casez (op)
      OP_BNE:  kind = BR_COND;
      OP_BEQ:  kind = BR_COND;
      OP_J:    kind = BR_JUMP;
      OP_CALL: kind = BR_CALL;
      OP_RET:  kind = BR_RET;
      default: kind = BR_NONE;
    endcase
    return kind;
  endfunction

  // Taken decision for a conditional branch: BNE wants zero clear, BEQ set
  function automatic logic cond_taken(input logic [6:0] op, input logic zero);
    return (op[6:3] == 4'b1001) ? ~zero : zero;
  endfunction

endpackage

// File: rtl/branch_unit_ras_stack.sv
// Circular return-address LIFO. A push when full overwrites the oldest entry,
// which is exactly the slot the write pointer lands on after wrapping.
// The pop data is read combinationally so the popped address can be
// registered as the redirect target in the same cycle the RET is accepted.
module ras_stack #(
  parameter int W     = 12,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [W-1:0]             push_data_i,
  output logic [W-1:0]             pop_data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] ptr_q, ptr_d;     // next slot to write; top of stack is ptr_q-1
  logic [CW-1:0] count_q, count_d;

  assign full_o     = (count_q == CW'(DEPTH));
  assign empty_o    = (count_q == '0);
  assign count_o    = count_q;
  assign pop_data_o = mem[ptr_q - PW'(1)];

  // Pointer/occupancy update; push and pop are never requested together
  always_comb begin
    ptr_d   = ptr_q;
    count_d = count_q;
    if (push_i) begin
      ptr_d = ptr_q + PW'(1);
      if (!full_o) count_d = count_q + CW'(1);
    end else if (pop_i) begin
      ptr_d   = ptr_q - PW'(1);
      count_d = count_q - CW'(1);
    end
  end

  // Pointer and count registers
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q   <= '0;
      count_q <= '0;
    end else begin
      ptr_q   <= ptr_d;
      count_q <= count_d;
    end
  end

  // Stack storage; contents are meaningless after reset so it is not cleared
  always_ff @(posedge clk) begin
    if (push_i) mem[ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/branch_unit_ras.sv
// Branch resolution unit with return-address stack. Resolves BNE/BEQ/J and
// CALL/RET, issues a registered one-cycle restart pulse and squashes the one
// shadow instruction after each restart.
// Optional macro BRANCH_STATS_EN adds taken_count_o and call_depth_max_o.
module branch_unit_ras
  import branch_pkg::*;
#(
  parameter int IA_WIDTH  = 12,
  parameter int RAS_DEPTH = 8,
  parameter int CNT_WIDTH = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         valid_i,
  input  logic [6:0]                   operation_i,
  input  logic                         alu_zero_i,
  input  logic [IA_WIDTH-1:0]          label1_i,
  input  logic [IA_WIDTH-1:0]          label2_i,
  input  logic [IA_WIDTH-1:0]          instr_addr_i,
  output logic                         restart_o,
  output logic [IA_WIDTH-1:0]          restart_addr_o,
  output logic [$clog2(RAS_DEPTH):0]   ras_count_o,
  output logic                         ras_overflow_o,
  output logic                         ras_underflow_o
`ifdef BRANCH_STATS_EN
  ,
  output logic [CNT_WIDTH-1:0]         taken_count_o,
  output logic [CNT_WIDTH-1:0]         call_depth_max_o
`endif
);

  localparam int CW = $clog2(RAS_DEPTH) + 1;

  logic                restart_q, restart_d;
  logic [IA_WIDTH-1:0] restart_addr_q, restart_addr_d;
  logic                squash_q, squash_d;
  logic                overflow_q, overflow_d;
  logic                underflow_q, underflow_d;

  logic                accept;
  br_kind_e            kind;
  logic [IA_WIDTH-1:0] normal_next;
  logic                push, pop;
  logic [IA_WIDTH-1:0] pop_data;
  logic                full, empty;
  logic [CW-1:0]       count;

  ras_stack #(
    .W     (IA_WIDTH),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push),
    .pop_i       (pop),
    .push_data_i (normal_next),
    .pop_data_o  (pop_data),
    .full_o      (full),
    .empty_o     (empty),
    .count_o     (count)
  );

  assign accept      = valid_i && !squash_q;
  assign kind        = decode_kind(operation_i);
  assign normal_next = instr_addr_i + IA_WIDTH'(1);

  // Branch decision, stack requests and next-state of the registered outputs
  always_comb begin
    restart_d      = 1'b0;
    restart_addr_d = restart_addr_q;
    push           = 1'b0;
    pop            = 1'b0;
    overflow_d     = overflow_q;
    underflow_d    = underflow_q;
    if (accept) begin
      case (kind)
        BR_COND: begin
          if (cond_taken(operation_i, alu_zero_i)) begin
            restart_d      = 1'b1;
            restart_addr_d = label1_i;
          end
        end
        BR_JUMP: begin
          restart_d      = 1'b1;
          restart_addr_d = label1_i + label2_i;
        end
        BR_CALL: begin
          push           = 1'b1;
          restart_d      = 1'b1;
          restart_addr_d = label1_i;
          if (full) overflow_d = 1'b1;
        end
        BR_RET: begin
          if (!empty) begin
            pop            = 1'b1;
            restart_d      = 1'b1;
            restart_addr_d = pop_data;
          end else begin
            underflow_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
    // The instruction right behind a restart is the shadow slot; kill it
    squash_d = restart_d;
  end

  // Output, squash and sticky-flag registers
  always_ff @(posedge clk) begin
    if (rst) begin
      restart_q      <= 1'b0;
      restart_addr_q <= '0;
      squash_q       <= 1'b0;
      overflow_q     <= 1'b0;
      underflow_q    <= 1'b0;
    end else begin
      restart_q      <= restart_d;
      restart_addr_q <= restart_addr_d;
      squash_q       <= squash_d;
      overflow_q     <= overflow_d;
      underflow_q    <= underflow_d;
    end
  end

  assign restart_o       = restart_q;
  assign restart_addr_o  = restart_addr_q;
  assign ras_count_o     = count;
  assign ras_overflow_o  = overflow_q;
  assign ras_underflow_o = underflow_q;

`ifdef BRANCH_STATS_EN
  logic [CNT_WIDTH-1:0] taken_count_q, taken_count_d;
  logic [CNT_WIDTH-1:0] depth_max_q, depth_max_d;
  logic [CW-1:0]        count_next;

  // Taken counter saturates; high-water mark tracks the occupancy being loaded
  always_comb begin
    if (push && !full) count_next = count + CW'(1);
    else if (pop)      count_next = count - CW'(1);
    else               count_next = count;
    taken_count_d = taken_count_q;
    if (restart_d && (taken_count_q != '1)) taken_count_d = taken_count_q + CNT_WIDTH'(1);
    depth_max_d = depth_max_q;
    if (CNT_WIDTH'(count_next) > depth_max_q) depth_max_d = CNT_WIDTH'(count_next);
  end

  // Statistics registers
  always_ff @(posedge clk) begin
    if (rst) begin
      taken_count_q <= '0;
      depth_max_q   <= '0;
    end else begin
      taken_count_q <= taken_count_d;
      depth_max_q   <= depth_max_d;
    end
  end

  assign taken_count_o    = taken_count_q;
  assign call_depth_max_o = depth_max_q;
`endif

endmodule

// File: tb/tb_branch_unit_ras.sv
// Directed bench for branch_unit_ras (default build, RAS_DEPTH=8, IA_WIDTH=12).
module tb_branch_unit_ras;

  localparam logic [6:0] BNE  = 7'b1001000;
  localparam logic [6:0] BEQ  = 7'b1010000;
  localparam logic [6:0] JMP  = 7'b1100000;
  localparam logic [6:0] CALL = 7'b1111011;
  localparam logic [6:0] RET  = 7'b1111100;
  localparam logic [6:0] NOP  = 7'b0000000;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_i;
  logic [6:0]  operation_i;
  logic        alu_zero_i;
  logic [11:0] label1_i;
  logic [11:0] label2_i;
  logic [11:0] instr_addr_i;
  logic        restart_o;
  logic [11:0] restart_addr_o;
  logic [3:0]  ras_count_o;
  logic        ras_overflow_o;
  logic        ras_underflow_o;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  branch_unit_ras #(
    .IA_WIDTH  (12),
    .RAS_DEPTH (8),
    .CNT_WIDTH (16)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .valid_i         (valid_i),
    .operation_i     (operation_i),
    .alu_zero_i      (alu_zero_i),
    .label1_i        (label1_i),
    .label2_i        (label2_i),
    .instr_addr_i    (instr_addr_i),
    .restart_o       (restart_o),
    .restart_addr_o  (restart_addr_o),
    .ras_count_o     (ras_count_o),
    .ras_overflow_o  (ras_overflow_o),
    .ras_underflow_o (ras_underflow_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs at the falling edge, then sample 1ns after the rise
  task automatic step(input logic r, input logic v, input logic [6:0] op, input logic z,
                      input logic [11:0] l1, input logic [11:0] l2, input logic [11:0] ia);
    @(negedge clk);
    rst = r; valid_i = v; operation_i = op; alu_zero_i = z;
    label1_i = l1; label2_i = l2; instr_addr_i = ia;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, NOP, 1'b0, 12'h000, 12'h000, 12'h000);
  endtask

  initial begin
    rst = 1'b1; valid_i = 1'b0; operation_i = NOP; alu_zero_i = 1'b0;
    label1_i = '0; label2_i = '0; instr_addr_i = '0;

    // Reset state
    step(1'b1, 1'b0, NOP, 1'b0, 12'h0, 12'h0, 12'h0);
    step(1'b1, 1'b0, NOP, 1'b0, 12'h0, 12'h0, 12'h0);
    chk("rst_restart", restart_o, 0);
    chk("rst_addr", restart_addr_o, 0);
    chk("rst_count", ras_count_o, 0);
    chk("rst_ovf", ras_overflow_o, 0);
    chk("rst_unf", ras_underflow_o, 0);
    $display("reset: restart=%0d addr=0x%03h count=%0d", restart_o, restart_addr_o, ras_count_o);

    // BEQ taken
    step(1'b0, 1'b1, BEQ, 1'b1, 12'h040, 12'h000, 12'h010);
    chk("beq_restart", restart_o, 1);
    chk("beq_addr", restart_addr_o, 12'h040);
    $display("BEQ z=1 @0x010 -> restart=%0d addr=0x%03h", restart_o, restart_addr_o);

    // Shadow BNE that would be taken is squashed
    step(1'b0, 1'b1, BNE, 1'b0, 12'h123, 12'h000, 12'h011);
    chk("shadow_restart", restart_o, 0);
    chk("shadow_addr_hold", restart_addr_o, 12'h040);
    $display("shadow BNE -> restart=%0d addr=0x%03h", restart_o, restart_addr_o);

    // BNE not taken
    step(1'b0, 1'b1, BNE, 1'b1, 12'h300, 12'h000, 12'h020);
    chk("bne_nt_restart", restart_o, 0);
    chk("bne_nt_addr", restart_addr_o, 12'h040);
    $display("BNE z=1 @0x020 -> restart=%0d", restart_o);

    // BEQ not taken
    step(1'b0, 1'b1, BEQ, 1'b0, 12'h333, 12'h000, 12'h021);
    chk("beq_nt_restart", restart_o, 0);
    $display("BEQ z=0 -> restart=%0d", restart_o);

    // J with wrap-around target
    step(1'b0, 1'b1, JMP, 1'b0, 12'hFF0, 12'h020, 12'h022);
    chk("j_restart", restart_o, 1);
    chk("j_addr_wrap", restart_addr_o, 12'h010);
    $display("J 0xFF0+0x020 -> restart=%0d addr=0x%03h", restart_o, restart_addr_o);
    idle();
    chk("j_shadow_idle", restart_o, 0);

    // Unrelated valid opcode: no restart, address holds
    step(1'b0, 1'b1, NOP, 1'b1, 12'h555, 12'h111, 12'h030);
    chk("nop_restart", restart_o, 0);
    chk("nop_addr_hold", restart_addr_o, 12'h010);
    $display("NOP -> restart=%0d addr=0x%03h", restart_o, restart_addr_o);

    // CALL then squashed RET then real RET
    step(1'b0, 1'b1, CALL, 1'b0, 12'h200, 12'h000, 12'h100);
    chk("call_restart", restart_o, 1);
    chk("call_addr", restart_addr_o, 12'h200);
    chk("call_count", ras_count_o, 1);
    $display("CALL @0x100 -> addr=0x%03h count=%0d", restart_addr_o, ras_count_o);
    step(1'b0, 1'b1, RET, 1'b0, 12'h000, 12'h000, 12'h200);
    chk("ret_shadow_restart", restart_o, 0);
    chk("ret_shadow_count", ras_count_o, 1);
    $display("shadow RET -> restart=%0d count=%0d", restart_o, ras_count_o);
    step(1'b0, 1'b1, RET, 1'b0, 12'h000, 12'h000, 12'h201);
    chk("ret_restart", restart_o, 1);
    chk("ret_addr", restart_addr_o, 12'h101);
    chk("ret_count", ras_count_o, 0);
    $display("RET -> addr=0x%03h count=%0d", restart_addr_o, ras_count_o);
    idle();

    // Nine CALLs overflow an 8-deep stack
    for (int i = 1; i <= 9; i++) begin
      step(1'b0, 1'b1, CALL, 1'b0, 12'h300 + 12'(i), 12'h000, 12'(i));
      chk("ovf_call_restart", restart_o, 1);
      chk("ovf_call_count", ras_count_o, (i > 8) ? 8 : i);
      chk("ovf_flag", ras_overflow_o, (i > 8) ? 1 : 0);
      $display("CALL @0x%03h -> count=%0d ovf=%0d", i, ras_count_o, ras_overflow_o);
      idle();
    end

    // Eight RETs unwind 0x00A..0x003
    for (int k = 0; k < 8; k++) begin
      step(1'b0, 1'b1, RET, 1'b0, 12'h000, 12'h000, 12'h400);
      chk("unwind_restart", restart_o, 1);
      chk("unwind_addr", restart_addr_o, 12'h00A - 12'(k));
      chk("unwind_count", ras_count_o, 7 - k);
      $display("RET -> addr=0x%03h count=%0d", restart_addr_o, ras_count_o);
      idle();
    end

    // RET on empty stack
    step(1'b0, 1'b1, RET, 1'b0, 12'h000, 12'h000, 12'h410);
    chk("empty_ret_restart", restart_o, 0);
    chk("empty_ret_unf", ras_underflow_o, 1);
    chk("empty_ret_count", ras_count_o, 0);
    chk("ovf_sticky", ras_overflow_o, 1);
    $display("RET empty -> restart=%0d unf=%0d", restart_o, ras_underflow_o);
    idle();
    chk("unf_sticky", ras_underflow_o, 1);

    // One-cycle reset clears sticky flags
    step(1'b1, 1'b0, NOP, 1'b0, 12'h0, 12'h0, 12'h0);
    chk("rst2_unf", ras_underflow_o, 0);
    chk("rst2_ovf", ras_overflow_o, 0);
    chk("rst2_count", ras_count_o, 0);
    $display("rst -> unf=%0d ovf=%0d count=%0d", ras_underflow_o, ras_overflow_o, ras_count_o);

    // Reset while a CALL's restart is out abandons the squash
    step(1'b0, 1'b1, CALL, 1'b0, 12'h060, 12'h000, 12'h050);
    chk("pre_rst_call", restart_o, 1);
    chk("pre_rst_count", ras_count_o, 1);
    step(1'b1, 1'b1, BEQ, 1'b1, 12'h0AA, 12'h000, 12'h051);
    chk("mid_rst_restart", restart_o, 0);
    chk("mid_rst_count", ras_count_o, 0);
    chk("mid_rst_addr", restart_addr_o, 0);
    step(1'b0, 1'b1, BEQ, 1'b1, 12'h070, 12'h000, 12'h071);
    chk("post_rst_beq", restart_o, 1);
    chk("post_rst_addr", restart_addr_o, 12'h070);
    $display("BEQ after reset -> restart=%0d addr=0x%03h", restart_o, restart_addr_o);
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
